// File: rtl/bitstream_decoder.sv
// Stochastic bitstream decoder: counts ones per channel over 2^WINDOW_LOG2
// valid samples and presents unipolar and bipolar results via valid/ready.
module bitstream_decoder #(
    parameter int CHANNEL_COUNT = 2,
    parameter int WINDOW_LOG2   = 8
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      start,
    input  logic                                      continuous,
    input  logic                                      stream_valid,
    input  logic [CHANNEL_COUNT-1:0]                  stream_in,
    output logic                                      busy,
    output logic                                      out_valid,
    input  logic                                      out_ready,
    output logic [CHANNEL_COUNT-1:0][WINDOW_LOG2:0]   out_count,
    output logic [CHANNEL_COUNT-1:0][WINDOW_LOG2+1:0] out_bipolar,
    output logic                                      overrun
);

    typedef enum logic {IDLE, ACCUM} state_t;

    localparam logic [WINDOW_LOG2-1:0] SAMPLE_ONE  = WINDOW_LOG2'(1);
    localparam logic [WINDOW_LOG2-1:0] SAMPLE_LAST = '1;
    localparam logic [WINDOW_LOG2+1:0] N_EXT =
        (WINDOW_LOG2+2)'(1) << WINDOW_LOG2;

    state_t state_q, state_d;

    logic [WINDOW_LOG2-1:0]                  sample_cnt;
    logic [CHANNEL_COUNT-1:0][WINDOW_LOG2:0] chan_cnt;
    logic [CHANNEL_COUNT-1:0][WINDOW_LOG2:0] chan_next;
    logic                                    take;
    logic                                    complete;
    logic                                    load;

    // Sample qualification, window end and result-load decisions
    always_comb begin
        take     = (state_q == ACCUM) && stream_valid && !start;
        complete = take && (sample_cnt == SAMPLE_LAST);
        load     = complete && (!out_valid || out_ready);
        for (int i = 0; i < CHANNEL_COUNT; i++) begin
            chan_next[i] = chan_cnt[i]
                         + {{WINDOW_LOG2{1'b0}}, stream_in[i]};
        end
    end

    // Next-state logic; start always (re)opens a window
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start) state_d = ACCUM;
            end
            ACCUM: begin
                if (start)         state_d = ACCUM;
                else if (complete) state_d = continuous ? ACCUM : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Sample and channel accumulators; cleared at start and window end
    always_ff @(posedge clk) begin
        if (rst || start) begin
            sample_cnt <= '0;
            chan_cnt   <= '0;
        end else if (complete) begin
            sample_cnt <= '0;
            chan_cnt   <= '0;
        end else if (take) begin
            sample_cnt <= sample_cnt + SAMPLE_ONE;
            chan_cnt   <= chan_next;
        end
    end

    // Result registers and output handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid   <= 1'b0;
            out_count   <= '0;
            out_bipolar <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_count <= chan_next;
            for (int i = 0; i < CHANNEL_COUNT; i++) begin
                out_bipolar[i] <= {chan_next[i], 1'b0} - N_EXT;
            end
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Sticky flag for a finished window lost to backpressure
    always_ff @(posedge clk) begin
        if (rst || start)                       overrun <= 1'b0;
        else if (complete && out_valid && !out_ready) overrun <= 1'b1;
    end

    assign busy = (state_q == ACCUM);

endmodule

// File: tb/tb_bitstream_decoder.sv
// Directed self-checking bench for bitstream_decoder with N=16, two channels.
module tb_bitstream_decoder;

    localparam int CH = 2;
    localparam int WL = 4;

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic                     start = 1'b0;
    logic                     continuous = 1'b0;
    logic                     stream_valid = 1'b0;
    logic [CH-1:0]            stream_in = '0;
    logic                     busy;
    logic                     out_valid;
    logic                     out_ready = 1'b0;
    logic [CH-1:0][WL:0]      out_count;
    logic [CH-1:0][WL+1:0]    out_bipolar;
    logic                     overrun;

    int checks = 0;
    int errors = 0;
    bit busy_dropped;

    bitstream_decoder #(.CHANNEL_COUNT(CH), .WINDOW_LOG2(WL)) dut (
        .clk(clk), .rst(rst), .start(start), .continuous(continuous),
        .stream_valid(stream_valid), .stream_in(stream_in), .busy(busy),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_count(out_count), .out_bipolar(out_bipolar),
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic sample(input bit b0, input bit b1);
        stream_valid = 1'b1;
        stream_in    = {b1, b0};
        tick();
        stream_valid = 1'b0;
        stream_in    = '0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic accept();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    function automatic int bip(input int ch);
        return int'($signed(out_bipolar[ch]));
    endfunction

    initial begin
        tick();
        tick();
        rst = 1'b0;
        chk("reset_busy", busy, 0);
        chk("reset_valid", out_valid, 0);
        chk("reset_count", out_count, 0);
        chk("reset_bipolar", out_bipolar, 0);
        chk("reset_overrun", overrun, 0);

        // Single window: ch0 all ones, ch1 alternating
        pulse_start();
        chk("single_busy_start", busy, 1);
        for (int i = 0; i < 16; i++) begin
            if (i == 15) chk("single_no_early_valid", out_valid, 0);
            sample(1'b1, (i % 2) == 0);
        end
        chk("single_valid", out_valid, 1);
        chk("single_count0", out_count[0], 16);
        chk("single_count1", out_count[1], 8);
        chk("single_bip0", bip(0), 16);
        chk("single_bip1", bip(1), 0);
        chk("single_busy_end", busy, 0);
        accept();
        chk("single_accepted", out_valid, 0);

        // Stalls interleaved, ch0 all zeros, ch1 all ones
        pulse_start();
        for (int i = 0; i < 16; i++) begin
            if (i == 15) chk("stall_no_early_valid", out_valid, 0);
            sample(1'b0, 1'b1);
            if (i < 10) tick();
        end
        chk("stall_valid", out_valid, 1);
        chk("stall_count0", out_count[0], 0);
        chk("stall_bip0", bip(0), -16);
        chk("stall_count1", out_count[1], 16);
        accept();

        // Backpressure across two continuous windows
        continuous = 1'b1;
        pulse_start();
        for (int i = 0; i < 16; i++) sample(i < 5, 1'b0);
        chk("bp_first_valid", out_valid, 1);
        chk("bp_first_count", out_count[0], 5);
        chk("bp_no_overrun_yet", overrun, 0);
        for (int i = 0; i < 16; i++) sample(1'b1, 1'b1);
        chk("bp_held_valid", out_valid, 1);
        chk("bp_held_count0", out_count[0], 5);
        chk("bp_held_count1", out_count[1], 0);
        chk("bp_overrun", overrun, 1);
        chk("bp_busy", busy, 1);
        continuous = 1'b0;
        accept();
        chk("bp_accepted", out_valid, 0);
        chk("bp_overrun_sticky", overrun, 1);
        tick();
        chk("bp_overrun_still", overrun, 1);

        // Back-to-back continuous windows with ready held high
        continuous = 1'b1;
        out_ready  = 1'b1;
        pulse_start();
        chk("b2b_overrun_cleared", overrun, 0);
        busy_dropped = 1'b0;
        for (int i = 0; i < 16; i++) begin
            sample(i < 4, 1'b0);
            if (!busy) busy_dropped = 1'b1;
        end
        chk("b2b_a_valid", out_valid, 1);
        chk("b2b_a_count", out_count[0], 4);
        for (int i = 0; i < 16; i++) begin
            sample(i < 12, 1'b1);
            if (i == 0) chk("b2b_a_taken", out_valid, 0);
            if (!busy) busy_dropped = 1'b1;
        end
        chk("b2b_b_valid", out_valid, 1);
        chk("b2b_b_count0", out_count[0], 12);
        chk("b2b_b_count1", out_count[1], 16);
        chk("b2b_busy_held", busy_dropped, 0);
        continuous = 1'b0;
        tick();
        out_ready = 1'b0;
        chk("b2b_drained", out_valid, 0);

        // Restart mid-window discards the partial window
        pulse_start();
        for (int i = 0; i < 7; i++) sample(1'b1, 1'b1);
        pulse_start();
        for (int i = 0; i < 16; i++) begin
            if (i == 15) chk("restart_no_partial", out_valid, 0);
            sample(i < 3, 1'b0);
        end
        chk("restart_valid", out_valid, 1);
        chk("restart_count0", out_count[0], 3);
        chk("restart_bip0", bip(0), -10);
        accept();

        // Reset mid-window aborts with no result
        pulse_start();
        for (int i = 0; i < 9; i++) sample(1'b1, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstmid_busy", busy, 0);
        chk("rstmid_valid", out_valid, 0);
        chk("rstmid_count", out_count, 0);
        chk("rstmid_bipolar", out_bipolar, 0);
        for (int i = 0; i < 16; i++) sample(1'b1, 1'b1);
        chk("idle_ignores_valid", out_valid, 0);
        chk("idle_busy", busy, 0);

        // Start colliding with the final sample discards the window
        pulse_start();
        for (int i = 0; i < 15; i++) sample(1'b1, 1'b1);
        start = 1'b1;
        sample(1'b1, 1'b1);
        start = 1'b0;
        chk("collide_no_result", out_valid, 0);
        chk("collide_busy", busy, 1);
        for (int i = 0; i < 16; i++) sample(1'b1, i < 2);
        chk("final_valid", out_valid, 1);
        chk("final_count0", out_count[0], 16);
        chk("final_count1", out_count[1], 2);
        chk("final_bip1", bip(1), -12);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
